// File: rtl/encoder_8x3_seq.sv
// rtl/encoder_8x3_seq.sv - registered 8-to-3 priority encoder with sticky pending vector
//
// Purpose:
//   Captures request lines into a sticky pending vector and emits one 3-bit
//   index per accepted transfer on a valid/ready output. The highest-priority
//   request is served first, and its bit is cleared when it is served.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   en         in   1      capture enable; D is ignored while low
//   D          in   8      request lines, bit i requests code i
//   out_valid  out  1      out_code/out_multi hold a valid result
//   out_ready  in   1      consumer accepts on out_valid & out_ready
//   out_code   out  3      encoded index of the served request
//   out_multi  out  1      more than one bit was pending when the code loaded
//   pending    out  8      current pending vector
//   drop_cnt   out  CNT_W  saturating count of cycles that lost a request

module encoder_8x3_seq #(
   parameter bit PRI_MSB = 1'b1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [7:0]       D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_code,
   output logic             out_multi,
   output logic [7:0]       pending,
   output logic [CNT_W-1:0] drop_cnt
);

   logic [7:0]       pending_q,   pending_d;
   logic             out_valid_q, out_valid_d;
   logic [2:0]       out_code_q,  out_code_d;
   logic             out_multi_q, out_multi_d;
   logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

   logic [7:0] d_masked;
   logic       load;
   logic [7:0] sel;
   logic [2:0] sel_idx;
   logic       drop;

   always_comb begin
      d_masked = en ? D : 8'h00;
      load     = !out_valid_q || out_ready;

      // The scan order makes the last hit win, so the scan runs toward the
      // highest-priority end.
      sel     = 8'h00;
      sel_idx = 3'd0;
      if (load) begin
         if (PRI_MSB) begin
            for (int i = 0; i < 8; i++) begin
               if (pending_q[i]) begin
                  sel     = 8'h01 << i;
                  sel_idx = 3'(i);
               end
            end
         end else begin
            for (int i = 7; i >= 0; i--) begin
               if (pending_q[i]) begin
                  sel     = 8'h01 << i;
                  sel_idx = 3'(i);
               end
            end
         end
      end

      // A request that is already pending and is not being served this cycle
      // merges into the existing bit, so it is lost.
      drop = |(d_masked & pending_q & ~sel);

      // A served bit that is requested again in the same cycle is re-captured.
      pending_d = (pending_q & ~sel) | d_masked;

      out_valid_d = out_valid_q;
      out_code_d  = out_code_q;
      out_multi_d = out_multi_q;
      if (load) begin
         if (pending_q != 8'h00) begin
            out_valid_d = 1'b1;
            out_code_d  = sel_idx;
            // More than one bit set <=> clearing the lowest set bit leaves something.
            out_multi_d = (pending_q & (pending_q - 8'd1)) != 8'h00;
         end else begin
            out_valid_d = 1'b0;
         end
      end

      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= 8'h00;
         out_valid_q <= 1'b0;
         out_code_q  <= 3'd0;
         out_multi_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         out_multi_q <= out_multi_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_multi = out_multi_q;
   assign pending   = pending_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// tb/tb_encoder_8x3_seq.sv - directed self-checking bench for encoder_8x3_seq

module tb_encoder_8x3_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] d;
   logic       out_ready;

   // Instance a: MSB priority, 8-bit counter.
   logic       a_valid, a_multi;
   logic [2:0] a_code;
   logic [7:0] a_pend;
   logic [7:0] a_drop;

   // Instance b: LSB priority.
   logic       b_valid, b_multi;
   logic [2:0] b_code;
   logic [7:0] b_pend;
   logic [7:0] b_drop;

   // Instance c: 2-bit counter for saturation.
   logic       c_valid, c_multi;
   logic [2:0] c_code;
   logic [7:0] c_pend;
   logic [1:0] c_drop;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   encoder_8x3_seq #(.PRI_MSB(1'b1), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .en(en), .D(d), .out_valid(a_valid), .out_ready(out_ready),
      .out_code(a_code), .out_multi(a_multi), .pending(a_pend), .drop_cnt(a_drop)
   );

   encoder_8x3_seq #(.PRI_MSB(1'b0), .CNT_W(8)) u_b (
      .clk(clk), .rst(rst), .en(en), .D(d), .out_valid(b_valid), .out_ready(out_ready),
      .out_code(b_code), .out_multi(b_multi), .pending(b_pend), .drop_cnt(b_drop)
   );

   encoder_8x3_seq #(.PRI_MSB(1'b1), .CNT_W(2)) u_c (
      .clk(clk), .rst(rst), .en(en), .D(d), .out_valid(c_valid), .out_ready(out_ready),
      .out_code(c_code), .out_multi(c_multi), .pending(c_pend), .drop_cnt(c_drop)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; sample and drive 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; d = 8'h00; out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check_eq("rst_valid", 32'(a_valid), 0);
      check_eq("rst_code",  32'(a_code),  0);
      check_eq("rst_multi", 32'(a_multi), 0);
      check_eq("rst_pend",  32'(a_pend),  0);
      check_eq("rst_drop",  32'(a_drop),  0);

      // 1. single request, two-edge latency
      d = 8'h04;
      tick();
      d = 8'h00;
      check_eq("t1_pend_e1",  32'(a_pend),  32'h04);
      check_eq("t1_valid_e1", 32'(a_valid), 0);
      tick();
      check_eq("t1_valid_e2", 32'(a_valid), 1);
      check_eq("t1_code_e2",  32'(a_code),  2);
      check_eq("t1_multi_e2", 32'(a_multi), 0);
      check_eq("t1_pend_e2",  32'(a_pend),  0);
      tick();
      check_eq("t1_valid_e3", 32'(a_valid), 0);
      check_eq("t1_code_hold", 32'(a_code), 2);

      // 2. two requests, priority order
      d = 8'hA0;
      tick();
      d = 8'h00;
      tick();
      check_eq("t2_msb_code0",  32'(a_code),  7);
      check_eq("t2_msb_multi0", 32'(a_multi), 1);
      check_eq("t2_msb_valid0", 32'(a_valid), 1);
      check_eq("t2_lsb_code0",  32'(b_code),  5);
      check_eq("t2_lsb_multi0", 32'(b_multi), 1);
      tick();
      check_eq("t2_msb_code1",  32'(a_code),  5);
      check_eq("t2_msb_multi1", 32'(a_multi), 0);
      check_eq("t2_msb_valid1", 32'(a_valid), 1);
      check_eq("t2_lsb_code1",  32'(b_code),  7);
      check_eq("t2_lsb_multi1", 32'(b_multi), 0);
      tick();
      check_eq("t2_idle", 32'(a_valid), 0);

      // 3. backpressure
      out_ready = 1'b0;
      d = 8'h81;
      tick();
      d = 8'h00;
      tick();
      check_eq("t3_code_load", 32'(a_code), 7);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("t3_hold_code",  32'(a_code),  7);
         check_eq("t3_hold_valid", 32'(a_valid), 1);
         check_eq("t3_hold_pend",  32'(a_pend),  32'h01);
      end
      out_ready = 1'b1;
      tick();
      check_eq("t3_code_next",  32'(a_code),  0);
      check_eq("t3_valid_next", 32'(a_valid), 1);
      check_eq("t3_multi_next", 32'(a_multi), 0);
      tick();
      check_eq("t3_idle",      32'(a_valid), 0);
      check_eq("t3_no_drops",  32'(a_drop),  0);

      // 4. drops while stalled, then en=0 masks D
      out_ready = 1'b0;
      d = 8'h01;
      for (int i = 0; i < 4; i++) tick();
      d = 8'h00;
      check_eq("t4_drop",  32'(a_drop),  2);
      check_eq("t4_pend",  32'(a_pend),  32'h01);
      check_eq("t4_valid", 32'(a_valid), 1);
      check_eq("t4_code",  32'(a_code),  0);
      en = 1'b0;
      d = 8'hFF;
      tick();
      tick();
      check_eq("t4_en0_pend", 32'(a_pend), 32'h01);
      check_eq("t4_en0_drop", 32'(a_drop), 2);
      en = 1'b1;
      d = 8'h00;

      // 5. reset mid-operation
      do_reset();
      out_ready = 1'b0;
      d = 8'hF0;
      tick();
      tick();
      d = 8'h00;
      check_eq("t5_pre_pend",  32'(a_pend),  32'hF0);
      check_eq("t5_pre_valid", 32'(a_valid), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("t5_valid", 32'(a_valid), 0);
      check_eq("t5_code",  32'(a_code),  0);
      check_eq("t5_multi", 32'(a_multi), 0);
      check_eq("t5_pend",  32'(a_pend),  0);
      check_eq("t5_drop",  32'(a_drop),  0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t5_no_stale", 32'(a_valid), 0);
      end

      // 6. saturation of a 2-bit counter; drops on edges 2..7
      out_ready = 1'b0;
      d = 8'hFF;
      for (int i = 0; i < 7; i++) tick();
      d = 8'h00;
      check_eq("t6_sat",     32'(c_drop), 3);
      check_eq("t6_wide",    32'(a_drop), 6);
      tick();
      check_eq("t6_sat_hold", 32'(c_drop), 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
